// File: rtl/bram_burst_reader.sv
// Burst read engine for a fixed-latency block RAM read port, streaming words out through a credit-limited skid FIFO.
// Optional build macro BURST_READER_STATS_EN adds a saturating stall_cnt output.
module bram_burst_reader #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   burst_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
`ifdef BURST_READER_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(SKID_DEPTH + RD_LAT + 2) + 1;
  localparam int RW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [RW-1:0]       remain;
  logic                iss_p0;
  logic                iss_last_p0;
  logic [RD_LAT-1:0]   vld_p;
  logic [RD_LAT-1:0]   last_p;

  logic [DATA_W-1:0]   fifo_d [SKID_DEPTH];
  logic                fifo_l [SKID_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   hold_d;

  logic                push;
  logic                pop;
  logic [OW-1:0]       occ;
  logic                can_issue;

  function automatic logic [OW-1:0] inflight_of(input logic stage0, input logic [RD_LAT-1:0] v);
    logic [OW-1:0] n;
    n = OW'(stage0);
    for (int i = 0; i < RD_LAT; i++) n = n + OW'(v[i]);
    return n;
  endfunction

`ifdef BURST_READER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction
`endif

  // The pop happening this cycle frees its slot, so SKID_DEPTH = RD_LAT+2 in-flight slots sustain one word per cycle.
  always_comb begin
    push      = vld_p[RD_LAT-1];
    pop       = (cnt != '0) && m_ready;
    occ       = OW'(cnt) + inflight_of(iss_p0, vld_p);
    can_issue = (occ < (OW'(SKID_DEPTH) + OW'(pop)));
    m_valid   = (cnt != '0);
    m_data    = m_valid ? fifo_d[rd_ptr] : hold_d;
    m_last    = m_valid & fifo_l[rd_ptr];
    busy      = (state != IDLE);
    ram_en    = iss_p0 | (|vld_p);
  end

  // Issue stage (_p0 travels with ram_addr) and the RAM latency tracking pipe
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      done        <= 1'b0;
      ram_addr    <= '0;
      nxt_addr    <= '0;
      remain      <= '0;
      iss_p0      <= 1'b0;
      iss_last_p0 <= 1'b0;
      vld_p       <= '0;
      last_p      <= '0;
    end else begin
      done      <= 1'b0;
      iss_p0    <= 1'b0;
      vld_p[0]  <= iss_p0;
      last_p[0] <= iss_last_p0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (burst_len == '0) begin
              done <= 1'b1;
            end else begin
              ram_addr    <= base_addr;
              nxt_addr    <= base_addr + ADDR_W'(1);
              remain      <= burst_len - RW'(1);
              iss_p0      <= 1'b1;
              iss_last_p0 <= (burst_len == RW'(1));
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (remain == '0) begin
            state <= DRAIN;
          end else if (can_issue) begin
            ram_addr    <= nxt_addr;
            nxt_addr    <= nxt_addr + ADDR_W'(1);
            remain      <= remain - RW'(1);
            iss_p0      <= 1'b1;
            iss_last_p0 <= (remain == RW'(1));
            if (remain == RW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid FIFO control
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      hold_d <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        hold_d <= fifo_d[rd_ptr];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_d[wr_ptr] <= ram_rd_data;
      fifo_l[wr_ptr] <= last_p[RD_LAT-1];
    end
  end

`ifdef BURST_READER_STATS_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
